// File: rtl/iwTypes.sv
// Shared CDMA/HBM types and constants used by the CDMA command arbiter.
// Holds the id-width rule, the command bundle and the default tag depth.
package iwTypes;

   localparam int HBM_ADDR_BITS = 34;
   localparam int HBM_LEN_BITS  = 28;

   localparam int CDMA_ARB_OUTSTANDING = 8;

   typedef struct packed {
      logic [HBM_ADDR_BITS-1:0] paddr;
      logic [HBM_LEN_BITS-1:0]  len;
   } cdma_cmd_t;

   function automatic int cdma_arb_id_bits(input int n_req);
      return (n_req > 1) ? $clog2(n_req) : 1;
   endfunction

endpackage

// File: rtl/cdma_arb_tag_fifo.sv
// In-order tag FIFO holding the requester id of every issued CDMA command.
// Registered pointers; occupancy count is exported for the issue limit.
module cdma_arb_tag_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 2
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PW+1)'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge aclk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cdma_cmd_arbiter.sv
// Round-robin arbiter sharing one CDMA command channel between requesters.
// Define CDMA_ARB_STATS_EN to add per-requester issue/done counters.
module cdma_cmd_arbiter
   import iwTypes::*;
#(
   parameter int N_REQ       = 4,
   parameter int ADDR_BITS   = HBM_ADDR_BITS,
   parameter int LEN_BITS    = HBM_LEN_BITS,
   parameter int OUTSTANDING = CDMA_ARB_OUTSTANDING
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [N_REQ-1:0]          s_valid,
   output logic [N_REQ-1:0]          s_ready,
   input  logic [N_REQ*ADDR_BITS-1:0] s_paddr,
   input  logic [N_REQ*LEN_BITS-1:0] s_len,
   output logic [N_REQ-1:0]          s_done,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [ADDR_BITS-1:0]      m_paddr,
   output logic [LEN_BITS-1:0]       m_len,
   input  logic                      m_done,
   output logic                      err_unexp_done
`ifdef CDMA_ARB_STATS_EN
   ,
   output logic [N_REQ*32-1:0]       stat_issued,
   output logic [N_REQ*32-1:0]       stat_done
`endif
);

   localparam int CDMA_ARB_ID_BITS = cdma_arb_id_bits(N_REQ);
   localparam int CW = $clog2(OUTSTANDING) + 1;

   logic [CDMA_ARB_ID_BITS-1:0] last_grant;
   logic [CDMA_ARB_ID_BITS-1:0] winner;
   logic [CDMA_ARB_ID_BITS-1:0] head;
   logic                        req_found;
   logic                        stage_free;
   logic                        grant;
   logic                        pop;
   logic                        fifo_empty;
   logic                        fifo_full;
   logic [CW-1:0]               fifo_count;
   logic                        unused_fifo_full;
   int                          idx;

   assign unused_fifo_full = fifo_full;

   // Search starts one past the previous winner so every requester rotates in.
   always_comb begin
      winner    = last_grant;
      req_found = 1'b0;
      idx       = 0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = int'(last_grant) + i;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (!req_found && s_valid[idx]) begin
            req_found = 1'b1;
            winner    = CDMA_ARB_ID_BITS'(idx);
         end
      end
   end

   assign stage_free = ~m_valid | m_ready;
   assign grant = stage_free & req_found &
                  (fifo_count < CW'(OUTSTANDING));
   assign pop   = m_done & ~fifo_empty;

   always_comb begin
      s_ready = '0;
      if (grant) begin
         s_ready[winner] = 1'b1;
      end
   end

   cdma_arb_tag_fifo #(
      .DEPTH (OUTSTANDING),
      .WIDTH (CDMA_ARB_ID_BITS)
   ) u_tag_fifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .push    (grant),
      .pop     (pop),
      .din     (winner),
      .dout    (head),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (fifo_count)
   );

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         m_valid        <= 1'b0;
         m_paddr        <= '0;
         m_len          <= '0;
         last_grant     <= CDMA_ARB_ID_BITS'(N_REQ - 1);
         s_done         <= '0;
         err_unexp_done <= 1'b0;
      end else begin
         if (grant) begin
            m_valid    <= 1'b1;
            m_paddr    <= s_paddr[int'(winner)*ADDR_BITS +: ADDR_BITS];
            m_len      <= s_len[int'(winner)*LEN_BITS +: LEN_BITS];
            last_grant <= winner;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
         s_done <= pop ? (N_REQ'(1) << head) : '0;
         if (m_done && fifo_empty) begin
            err_unexp_done <= 1'b1;
         end
      end
   end

`ifdef CDMA_ARB_STATS_EN
   logic [31:0] iss_q  [N_REQ];
   logic [31:0] done_q [N_REQ];

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         for (int i = 0; i < N_REQ; i++) begin
            iss_q[i]  <= '0;
            done_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (grant && (winner == CDMA_ARB_ID_BITS'(i))) begin
               iss_q[i] <= iss_q[i] + 1'b1;
            end
            if (pop && (head == CDMA_ARB_ID_BITS'(i))) begin
               done_q[i] <= done_q[i] + 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < N_REQ; g++) begin : g_stat
      assign stat_issued[g*32 +: 32] = iss_q[g];
      assign stat_done[g*32 +: 32]   = done_q[g];
   end
`endif

endmodule

// File: tb/tb_cdma_cmd_arbiter.sv
// Scoreboard bench for cdma_cmd_arbiter: directed vectors push expectations,
// a negedge monitor pops and compares commands and completion pulses.
module tb_cdma_cmd_arbiter;
   import iwTypes::*;

   localparam int N  = 4;
   localparam int AW = HBM_ADDR_BITS;
   localparam int LW = HBM_LEN_BITS;

   typedef struct {
      logic [AW-1:0] paddr;
      logic [LW-1:0] len;
      int            cyc;
   } cmd_exp_t;

   typedef struct {
      int id;
      int cyc;
   } done_exp_t;

   logic              aclk = 1'b0;
   logic              aresetn;
   logic [N-1:0]      s_valid;
   logic [N-1:0]      s_ready;
   logic [N*AW-1:0]   s_paddr;
   logic [N*LW-1:0]   s_len;
   logic [N-1:0]      s_done;
   logic              m_valid;
   logic              m_ready;
   logic [AW-1:0]     m_paddr;
   logic [LW-1:0]     m_len;
   logic              m_done;
   logic              err_unexp_done;
`ifdef CDMA_ARB_STATS_EN
   logic [N*32-1:0]   stat_issued;
   logic [N*32-1:0]   stat_done;
`endif

   logic [AW-1:0] paddr_v [N];
   logic [LW-1:0] len_v   [N];

   cmd_exp_t  exp_cmd  [$];
   done_exp_t exp_done [$];
   int        tags     [$];
   int        iss_cnt  [N];
   int        done_cnt [N];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit cmd_any_cyc = 1'b0;

   cmd_exp_t  ce;
   done_exp_t de;

   cdma_cmd_arbiter #(
      .N_REQ       (N),
      .ADDR_BITS   (AW),
      .LEN_BITS    (LW),
      .OUTSTANDING (8)
   ) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_paddr        (s_paddr),
      .s_len          (s_len),
      .s_done         (s_done),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_paddr        (m_paddr),
      .m_len          (m_len),
      .m_done         (m_done),
      .err_unexp_done (err_unexp_done)
`ifdef CDMA_ARB_STATS_EN
      ,
      .stat_issued    (stat_issued),
      .stat_done      (stat_done)
`endif
   );

   always #5 aclk = ~aclk;

   always @(posedge aclk) cyc <= cyc + 1;

   for (genvar g = 0; g < N; g++) begin : g_drv
      assign paddr_v[g] = AW'(32'h1000 * g);
      assign len_v[g]   = (g == 2) ? '0 : LW'(32'h40 << g);
      assign s_paddr[g*AW +: AW] = paddr_v[g];
      assign s_len[g*LW +: LW]   = len_v[g];
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // One cycle: drive inputs, check s_ready, record expectations.
   task automatic drive(input logic [N-1:0] v, input logic rdy,
                        input logic dn, input logic [N-1:0] exp_rdy);
      int id;
      s_valid = v;
      m_ready = rdy;
      m_done  = dn;
      @(negedge aclk);
      chk("s_ready", 64'(s_ready), 64'(exp_rdy));
      if (dn && tags.size() > 0) begin
         id = tags.pop_front();
         exp_done.push_back('{id: id, cyc: cyc + 1});
         done_cnt[id]++;
      end
      if (exp_rdy != '0) begin
         id = 0;
         for (int i = 0; i < N; i++) if (exp_rdy[i]) id = i;
         exp_cmd.push_back('{paddr: paddr_v[id], len: len_v[id],
                             cyc: cmd_any_cyc ? -1 : cyc + 1});
         tags.push_back(id);
         iss_cnt[id]++;
      end
      @(posedge aclk);
      #1;
   endtask

   always @(negedge aclk) begin
      if (m_valid && m_ready) begin
         if (exp_cmd.size() == 0) begin
            chk("cmd_unexpected", 64'(m_paddr), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            ce = exp_cmd.pop_front();
            chk("m_paddr", 64'(m_paddr), 64'(ce.paddr));
            chk("m_len", 64'(m_len), 64'(ce.len));
            if (ce.cyc >= 0) chk("cmd_cycle", 64'(cyc), 64'(ce.cyc));
         end
      end
      if (s_done != '0) begin
         if (exp_done.size() == 0) begin
            chk("done_unexpected", 64'(s_done), 64'd0);
         end else begin
            de = exp_done.pop_front();
            chk("s_done", 64'(s_done), 64'(1) << de.id);
            chk("done_cycle", 64'(cyc), 64'(de.cyc));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         iss_cnt[i]  = 0;
         done_cnt[i] = 0;
      end
      aresetn = 1'b0;
      s_valid = '0;
      m_ready = 1'b0;
      m_done  = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_paddr", 64'(m_paddr), 64'd0);
      chk("rst_m_len", 64'(m_len), 64'd0);
      chk("rst_s_done", 64'(s_done), 64'd0);
      chk("rst_err", 64'(err_unexp_done), 64'd0);
      aresetn = 1'b1;

      // all four requesting: 0,1,2,3 one per cycle
      for (int i = 0; i < N; i++) drive(4'hF, 1'b1, 1'b0, 4'(1 << i));
      repeat (4) drive(4'h0, 1'b1, 1'b1, 4'h0);

      // requesters 1 and 3 alternate, done keeps count steady
      for (int i = 0; i < 20; i++)
         drive(4'b1010, 1'b1, i > 0, (i % 2 == 0) ? 4'b0010 : 4'b1000);
      drive(4'h0, 1'b1, 1'b1, 4'h0);

      // fill to 8 outstanding, then done frees one slot a cycle later
      repeat (8) drive(4'b0001, 1'b1, 1'b0, 4'b0001);
      drive(4'b0001, 1'b1, 1'b0, 4'b0000);
      drive(4'b0001, 1'b1, 1'b1, 4'b0000);
      drive(4'b0001, 1'b1, 1'b0, 4'b0001);
      repeat (8) drive(4'h0, 1'b1, 1'b1, 4'h0);

      // completion routing for issue order 2,0,2
      drive(4'b0100, 1'b1, 1'b0, 4'b0100);
      drive(4'b0001, 1'b1, 1'b0, 4'b0001);
      drive(4'b0100, 1'b1, 1'b0, 4'b0100);
      repeat (3) drive(4'h0, 1'b1, 1'b1, 4'h0);

      // back-pressure holds the command, release grants same cycle
      cmd_any_cyc = 1'b1;
      drive(4'b0010, 1'b1, 1'b0, 4'b0010);
      cmd_any_cyc = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_m_valid", 64'(m_valid), 64'd1);
         chk("stall_m_paddr", 64'(m_paddr), 64'(paddr_v[1]));
         chk("stall_m_len", 64'(m_len), 64'(len_v[1]));
         drive(4'b0010, 1'b0, 1'b0, 4'b0000);
      end
      drive(4'b1000, 1'b1, 1'b0, 4'b1000);
      repeat (2) drive(4'h0, 1'b1, 1'b1, 4'h0);
      drive(4'h0, 1'b1, 1'b0, 4'h0);
      chk("err_clear", 64'(err_unexp_done), 64'd0);

`ifdef CDMA_ARB_STATS_EN
      for (int i = 0; i < N; i++) begin
         chk("stat_issued", 64'(stat_issued[i*32 +: 32]), 64'(iss_cnt[i]));
         chk("stat_done", 64'(stat_done[i*32 +: 32]), 64'(done_cnt[i]));
      end
`endif

      // done with nothing outstanding
      drive(4'h0, 1'b1, 1'b1, 4'h0);
      chk("err_set", 64'(err_unexp_done), 64'd1);
      repeat (3) drive(4'h0, 1'b1, 1'b0, 4'h0);
      chk("err_sticky", 64'(err_unexp_done), 64'd1);

      // reset with a tag outstanding discards it
      drive(4'b0001, 1'b1, 1'b0, 4'b0001);
      drive(4'h0, 1'b1, 1'b0, 4'h0);
      aresetn = 1'b0;
      tags.delete();
      repeat (2) @(posedge aclk);
      #1;
      chk("rst2_err", 64'(err_unexp_done), 64'd0);
      chk("rst2_m_valid", 64'(m_valid), 64'd0);
      aresetn = 1'b1;
      drive(4'h0, 1'b1, 1'b1, 4'h0);
      chk("err_after_rst", 64'(err_unexp_done), 64'd1);
      repeat (3) drive(4'h0, 1'b1, 1'b0, 4'h0);

      chk("cmd_queue_empty", 64'(exp_cmd.size()), 64'd0);
      chk("done_queue_empty", 64'(exp_done.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
